// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult iterative multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_mult_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_sign.sv
// Combinational conditional two's-complement negate; yields the magnitude
// of a signed operand or re-applies the sign to an unsigned product.
module seq_mult_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Negate when requested; the most negative value maps onto its unsigned magnitude.
  always_comb begin
    res_o = val_i;
    if (neg_i) begin
      res_o = ~val_i + {{(W-1){1'b0}}, 1'b1};
    end else begin
      res_o = val_i;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-and-add multiplier with ready/valid handshakes.
// Define SEQ_MULT_SIGNED_EN to enable the sign-magnitude signed mode.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   C,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  seq_mult_state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    c_q, c_d;

  logic             accept_s;
  logic             out_hs_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [PW-1:0]    sum_s;
  logic [PW-1:0]    result_s;

  assign accept_s = in_valid & (state_q == IDLE);
  assign out_hs_s = out_ready & (state_q == DONE);
  assign sum_s    = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_a_s;
  logic sign_b_s;
  logic neg_q;

  assign sign_a_s = is_signed & A[WIDTH-1];
  assign sign_b_s = is_signed & B[WIDTH-1];

  seq_mult_sign #(.W(WIDTH)) u_sign_a (.val_i(A),     .neg_i(sign_a_s), .res_o(mag_a_s));
  seq_mult_sign #(.W(WIDTH)) u_sign_b (.val_i(B),     .neg_i(sign_b_s), .res_o(mag_b_s));
  seq_mult_sign #(.W(PW))    u_sign_c (.val_i(sum_s), .neg_i(neg_q),    .res_o(result_s));

  // Result sign captured with the operands; magnitudes are multiplied unsigned.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else if (accept_s) begin
      neg_q <= sign_a_s ^ sign_b_s;
    end else begin
      neg_q <= neg_q;
    end
  end
`else
  logic unused_is_signed_s;

  assign unused_is_signed_s = is_signed;
  assign mag_a_s            = A;
  assign mag_b_s            = B;
  assign result_s           = sum_s;
`endif

  // State register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: BUSY lasts exactly WIDTH cycles, no early exit on zero operands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = BUSY;
        else          state_d = IDLE;
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) state_d = DONE;
        else                  state_d = BUSY;
      end
      DONE: begin
        if (out_hs_s) state_d = IDLE;
        else          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: load on acceptance, one shift-and-add step per BUSY cycle.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    c_d      = c_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a_s};
          mplier_d = mag_b_s;
          acc_d    = {PW{1'b0}};
          cnt_d    = CNT_LOAD;
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        acc_d    = sum_s;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
        // The final step's sum goes straight into C so out_valid and C rise together.
        if (cnt_q == CNT_ONE) c_d = result_s;
        else                  c_d = c_q;
      end
      default: c_d = c_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= {PW{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {PW{1'b0}};
      c_q      <= {PW{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
    end
  end

  assign C = c_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard testbench for seq_mult (WIDTH=32); honours SEQ_MULT_SIGNED_EN.
module tb_seq_mult;

  localparam int W = 32;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          is_signed = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*W-1:0] C;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int          stamp_q[$];

  seq_mult #(.WIDTH(W)) dut (
    .CLK(CLK), .rst_n(rst_n), .A(A), .B(B), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(in_ready), .C(C),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] r;
    r = {32'd0, a} * {32'd0, b};
    if (SGN && s) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return r;
  endfunction

  // Cycle counter and acceptance time-stamps (values seen just before the edge).
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) stamp_q.push_back(cyc);
  end

  // Monitor: handshake, latency, hold-stability and product checks.
  logic        prev_ov = 1'b0;
  logic        prev_hs = 1'b0;
  logic [63:0] prev_c  = '0;
  always @(negedge CLK) begin
    logic hs;
    int   k;
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (exp_q.size() == 0)});
      if (out_valid && !prev_ov) begin
        if (stamp_q.size() == 0) fail_now("spurious_out_valid");
        else begin
          k = stamp_q.pop_front();
          // Stamp k is taken before the accept edge; cyc is one past edge k+W here.
          chk("latency", 64'(cyc - k), 64'(W + 1));
        end
      end
      if (out_valid && prev_ov && !prev_hs) chk("hold_C", C, prev_c);
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else chk("product", C, exp_q.pop_front());
      end
      prev_ov = out_valid;
      prev_c  = C;
      prev_hs = hs;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] e);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_ready) fail_now("issue_timeout");
    else begin
      A = a; B = b; is_signed = s; in_valid = 1'b1;
      @(posedge CLK);
      exp_q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) fail_now("drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          n;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_C", C, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge CLK); #1;

    // Basic latency, with an in_valid pulse during BUSY that must be ignored.
    issue(32'd3, 32'd5, 1'b0, 64'd15);
    A = 32'd9; B = 32'd9; in_valid = 1'b1;
    repeat (5) @(posedge CLK);
    #1 in_valid = 1'b0;

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
    issue(32'd0, 32'h12345678, 1'b0, 64'd0);
    issue(32'h12345678, 32'h10, 1'b0, 64'h0000000123456780);
    issue(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000);
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000FFFFFFFF);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, SGN ? 64'd1 : 64'hFFFFFFFE00000001);
    issue(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    issue(32'hFFFFFFFE, 32'd3, 1'b1, SGN ? 64'hFFFFFFFFFFFFFFFA : 64'h00000002FFFFFFFA);
    issue(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, SGN ? 64'd42 : 64'hFFFFFFF30000002A);
    issue(32'd7, 32'hFFFFFFFA, 1'b1, SGN ? 64'hFFFFFFFFFFFFFFD6 : 64'h00000006FFFFFFD6);
    drain();

    // Back-pressure: stall in DONE for 10 cycles while offering another operand pair.
    out_ready = 1'b0;
    issue(32'hDEADBEEF, 32'd2, 1'b0, 64'h00000001BD5B7DDE);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!out_valid) fail_now("bp_wait_timeout");
    A = 32'd1; B = 32'd1; in_valid = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset 10 cycles into BUSY discards the operation.
    issue(32'h0000ABCD, 32'h00001234, 1'b0, 64'h000000000C374FA4);
    repeat (10) @(posedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_C", C, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    stamp_q.delete();
    @(posedge CLK);
    #2 rst_n = 1'b1;
    @(posedge CLK); #1;
    issue(32'd7, 32'd6, 1'b0, 64'd42);
    drain();

    // Streaming with out_ready held high.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, model(ra, rb, rs));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
